ahb_sram_slv: RTL
=================

Name: ahb_sram_slv

Overview:
AHB-Lite responder that terminates the slave end of the team's AHB interface. It implements a word-organised register-array memory with byte-lane writes and a configurable number of wait states. It returns a two-cycle ERROR response for illegal transfers. It sits behind the address decoder and is the reference slave for master-driver and monitor bring-up.

Parameters:
AWIDTH, 32, haddr width (matches AHB_AWIDTH)
DWIDTH, 32, hwdata/hrdata width; only 32 is supported
MEM_WORDS, 256, memory depth in DWIDTH words; power of two
WAIT_STATES, 0, hready-low cycles inserted before each OKAY data phase completes (0..15)

Ports:
hclk  input  1  clock; all logic on rising edge
hreset  input  1  asynchronous active-high reset
hsel  input  1  slave select from decoder
haddr  input  AWIDTH  byte address
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write
hsize  input  3  transfer size, encoded as log2(bytes)
hburst  input  3  ignored
hprot  input  4  ignored
hmastlock  input  1  ignored
hwdata  input  DWIDTH  write data, valid in the data phase
hrdata  output  DWIDTH  read data
hready  output  1  transfer done / address phase accepted
hresp  output  1  0 OKAY, 1 ERROR

Behaviour:
- Interface: one clock hclk; reset hreset is asynchronous and active-high.
- Reset values: hready=1, hresp=0, hrdata=0, FSM=IDLE, no pending transfer. Memory array is not reset.
- Address phase accepted: on a rising edge where hsel & htrans[1] & hready are all 1. haddr, hwrite and hsize are registered at that edge. SEQ is handled identically to NONSEQ; each burst beat is an independent transfer.
- IDLE or BUSY while selected, or any unselected cycle: the next cycle is zero-wait OKAY and produces no memory access.
- Error check at acceptance. A transfer is illegal if any of the following holds:
  - hsize > 2;
  - haddr is not aligned to hsize (half: haddr[0]!=0; word: haddr[1:0]!=0);
  - haddr[AWIDTH-1:2] >= MEM_WORDS.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - Legal accept with WAIT_STATES=0: stay IDLE; data phase completes next cycle with hready=1, hresp=0.
  - Legal accept with WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES.
  - Illegal accept: go to ERR1.
- WAIT: hready=0, hresp=0, counter decrements each cycle. At counter==1, return to IDLE; the following cycle completes with hready=1.
- ERR1: hready=0, hresp=1; always goes to ERR2.
- ERR2: hready=1, hresp=1.
  - A new address phase may be accepted in ERR2, since hready=1; it follows the IDLE transition rules.
  - With no accept, go to IDLE.
  - An errored transfer performs no memory write.
- Write commit: occurs on the completing data-phase edge (hready=1, hresp=0), using hwdata from that cycle.
  - Byte lanes are little-endian, selected by hsize and addr_q[1:0].
  - Byte: lane addr_q[1:0]. Half: lanes {addr_q[1],0}..+1. Word: all lanes.
  - Unselected lanes are unchanged.
- Read data: hrdata = full word mem[addr_q word index] whenever the read data phase is completing (hready=1, hresp=0); otherwise hrdata=0. The master extracts its lanes.
- Read-after-write: a write whose data phase completes on cycle N, followed by a read whose data phase completes on N+1 to the same word, returns the new data.
- Reset mid-transfer: any pending write is discarded and the FSM returns to IDLE with reset output values.

Test Plan:
- Zero-wait write then read, WAIT_STATES=0: NONSEQ write 0x10, hwdata=0xDEADBEEF; then NONSEQ read 0x10 -> read data phase has hready=1, hresp=0, hrdata=0xDEADBEEF. Write-to-read back-to-back covers the forwarding case.
- Byte lanes: word write 0x20 with 0x00000000, then byte write 0x22 with hwdata=0x00AB0000, then halfword write 0x20 with 0x00001234 -> word read 0x20 returns 0x00AB1234.
- Wait states, WAIT_STATES=2: a read accepted on cycle N gives hready=0 on N+1 and N+2, then hready=1 with valid hrdata on N+3; hresp=0 throughout.
- Errors:
  - word read at 0x02 -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1);
  - hsize=3 gives the same response;
  - write at 0x400 (MEM_WORDS=256) gives the same response, and a subsequent read shows the target memory unchanged.
- Pipelined burst: 4-beat INCR4 word writes 0x40..0x4C, then a 4-beat read -> data 0x1,0x2,0x3,0x4 returned on consecutive cycles; IDLE/BUSY interleaved beats cause zero-wait OKAY.
- Reset mid-WAIT: assert hreset during a WAIT of a write -> outputs immediately reach reset values; the target word remains at its old value.

Source files
------------

// File: rtl/ahb_sram_slv_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slv_if
// AHB-Lite bus bundle between a master (or decoder path) and the SRAM slave.
//   master modport : drives hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
//                    hmastlock, hwdata; samples hrdata, hready, hresp
//   slave modport  : the mirror image of the master modport
// Clock and reset are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface ahb_sram_slv_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              hsel;
  logic [AWIDTH-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [DWIDTH-1:0] hwdata;
  logic [DWIDTH-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_sram_slv.sv
// ---------------------------------------------------------------------------
// ahb_sram_slv
// AHB-Lite responder backed by a word-organised register array. Supports
// byte/half/word writes through little-endian byte lanes, a fixed number of
// wait states before each OKAY data phase, and a two-cycle ERROR response for
// oversized, misaligned or out-of-range transfers.
// Ports:
//   hclk   : clock, all logic on the rising edge
//   hreset : asynchronous active-high reset
//   bus    : ahb_sram_slv_if.slave (address/control/write data in,
//            hrdata/hready/hresp out)
// Only DWIDTH = 32 is supported; MEM_WORDS must be a power of two (>= 2).
// ---------------------------------------------------------------------------
module ahb_sram_slv #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahb_sram_slv_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic               pend_q;
  logic               write_q;
  logic [1:0]         size_q;
  logic [IDX_W+1:0]   addr_q;
  logic               hready_q;
  logic               hresp_q;

  logic [DWIDTH-1:0]  mem [MEM_WORDS];

  logic               accept;
  logic               misaligned;
  logic               out_of_range;
  logic               illegal;
  logic               complete;
  logic [3:0]         lane_en;
  logic [DWIDTH-1:0]  rdata;

  // Burst type, protection and lock carry no meaning for a plain memory.
  wire unused_ctrl = ^{bus.hburst, bus.hprot, bus.hmastlock};

  assign accept = bus.hsel & bus.htrans[1] & hready_q;

  // Alignment depends on the transfer size; sizes above word are caught
  // separately so they need no alignment term here.
  always_comb begin
    misaligned = 1'b0;
    case (bus.hsize)
      3'd1:    misaligned = bus.haddr[0];
      3'd2:    misaligned = |bus.haddr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = ({2'b00, bus.haddr[AWIDTH-1:2]} >= AWIDTH'(MEM_WORDS));
  assign illegal      = (bus.hsize > 3'd2) | misaligned | out_of_range;

  // A legal transfer's data phase finishes in the cycle where hready is
  // back high; errored transfers never set pend_q, so they cannot complete.
  assign complete = pend_q & hready_q & ~hresp_q;

  // Transfer FSM. hready/hresp are registered so they change only on the
  // clock edge; IDLE and ERR2 share the acceptance rules because both
  // present hready=1 to the master.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      pend_q   <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          pend_q   <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept) begin
            addr_q  <= bus.haddr[IDX_W+1:0];
            write_q <= bus.hwrite;
            size_q  <= bus.hsize[1:0];
            if (illegal) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else begin
              pend_q <= 1'b1;
              if (WAIT_STATES != 0) begin
                state    <= ST_WAIT;
                wait_cnt <= 4'(WAIT_STATES);
                hready_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  // Little-endian lane selection from the registered size and offset.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'd0:    lane_en = 4'b0001 << addr_q[1:0];
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Memory contents survive reset; a reset clears pend_q asynchronously,
  // which is what drops a pending write.
  always_ff @(posedge hclk) begin
    if (complete & write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[addr_q[IDX_W+1:2]][8*i +: 8] <= bus.hwdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational read port: a write committed on the previous edge is
  // already visible, so back-to-back write/read needs no bypass.
  always_comb begin
    rdata = '0;
    if (complete & ~write_q) begin
      rdata = mem[addr_q[IDX_W+1:2]];
    end
  end

  assign bus.hrdata = rdata;
  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;

endmodule
